cordic_arbiter: RTL and testbench

Round-robin scheduler sharing one pipelined `cordic` sine engine between `N_REQ` requesters. It accepts angle/amplitude jobs over per-requester valid/ready handshakes and issues at most one job per cycle into the CORDIC. A tag delay line matched to the CORDIC latency returns each result stamped with the originating requester ID. It sits between motor/waveform-generation clients and the single CORDIC instance.

---
 rtl/cordic_arb_pkg.sv | 21 ++
 rtl/cordic_tag_pipe.sv | 31 +++
 rtl/cordic_arbiter.sv | 149 ++++++++++++++
 tb/tb_cordic_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared types and constants for the CORDIC round-robin arbiter.
package cordic_arb_pkg;

    localparam int ANGLE_W = 20;
    localparam logic [ANGLE_W-1:0] ANGLE_90 = 20'h40000;

    // Widest requester ID supported (N_REQ up to 8)
    localparam int ID_MAX_W = 3;

    // One slot of the tag delay line
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    // Requester ID width; never narrower than one bit
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cordic_tag_pipe.sv
// Fixed-depth {valid, id} delay line that tracks jobs through the CORDIC.
// Never stalls; reset drops every tag in flight.
module cordic_tag_pipe
    import cordic_arb_pkg::*;
#(
    parameter int DEPTH = 11
) (
    input  logic clock,
    input  logic reset,
    input  tag_t i_tag,
    output tag_t o_tag,
    output logic o_busy
);

    tag_t [DEPTH-1:0] r_stage;

    // Shift one stage per cycle, synchronous clear
    always_ff @(posedge clock) begin
        if (reset) r_stage <= '0;
        else       r_stage <= {r_stage[DEPTH-2:0], i_tag};
    end

    assign o_tag = r_stage[DEPTH-1];

    // Any valid tag anywhere means a job is in flight
    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) o_busy = o_busy | r_stage[i].valid;
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin scheduler feeding one pipelined CORDIC sine engine from N_REQ
// requesters; results come back stamped with the requester ID.
// Optional macro CORDIC_ARB_CREDIT_EN: per-requester outstanding-job limit
// of MAX_OUT; a requester at its limit is skipped by the scan.
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH   = 10,
    parameter  int LATENCY = 10,
    parameter  int MAX_OUT = 4,
    localparam int ID_W    = id_width(N_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [ANGLE_W*N_REQ-1:0] req_angle,
    input  logic [WIDTH*N_REQ-1:0]   req_amp,
    output logic [N_REQ-1:0]         req_ready,
    output logic [ANGLE_W-1:0]       cordic_angle,
    output logic [WIDTH-1:0]         cordic_x_start,
    output logic [WIDTH-1:0]         cordic_y_start,
    input  logic [WIDTH-1:0]         cordic_sine,
    output logic                     res_valid,
    output logic [ID_W-1:0]          res_id,
    output logic [WIDTH-1:0]         res_sine,
    output logic                     busy
);

    logic [ID_W-1:0]    r_ptr;
    logic [ANGLE_W-1:0] r_angle;
    logic [WIDTH-1:0]   r_amp;
    logic [N_REQ-1:0]   w_eligible;
    logic [ID_W-1:0]    w_scan;
    logic [ID_W-1:0]    w_pick;
    logic               w_found;
    logic               w_accept;
    logic [ANGLE_W-1:0] w_sel_angle;
    logic [WIDTH-1:0]   w_sel_amp;
    tag_t               w_tag_in;
    tag_t               w_tag_out;
    logic               w_tag_unused;

`ifdef CORDIC_ARB_CREDIT_EN
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    logic [N_REQ-1:0][CNT_W-1:0] r_cnt;

    // Outstanding-job counters: +1 on accept, -1 on returning result
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({w_accept && w_pick == ID_W'(i), res_valid && res_id == ID_W'(i)})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // Eligible only while below the outstanding limit
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            w_eligible[i] = req_valid[i] && (r_cnt[i] != CNT_W'(MAX_OUT));
    end
`else
    logic w_max_out_unused;
    assign w_max_out_unused = (MAX_OUT > 0);
    assign w_eligible       = req_valid;
`endif

    // First eligible index scanning upward from r_ptr; reverse loop so the
    // closest one to r_ptr is written last and wins
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_scan = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (w_eligible[w_scan]) begin
                w_found = 1'b1;
                w_pick  = w_scan;
            end
        end
    end

    // Reset wins over a same-cycle offer
    assign w_accept = w_found && !reset;

    // One-hot grant plus mux of the granted requester's job
    always_comb begin
        req_ready   = '0;
        w_sel_angle = '0;
        w_sel_amp   = '0;
        if (w_accept) req_ready[w_pick] = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == ID_W'(i)) begin
                w_sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
                w_sel_amp   = req_amp[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pointer moves past the granted requester
    always_ff @(posedge clock) begin
        if (reset)         r_ptr <= '0;
        else if (w_accept) r_ptr <= ID_W'((int'(w_pick) + 1) % N_REQ);
    end

    // Issue register; idle cycles feed zeros into the CORDIC
    always_ff @(posedge clock) begin
        if (reset) begin
            r_angle <= '0;
            r_amp   <= '0;
        end else if (w_accept) begin
            r_angle <= w_sel_angle;
            r_amp   <= w_sel_amp;
        end else begin
            r_angle <= '0;
            r_amp   <= '0;
        end
    end

    assign cordic_angle   = r_angle;
    assign cordic_x_start = r_amp;
    assign cordic_y_start = '0;

    // Stage 0 matches the issue register; LATENCY more stages cover the CORDIC
    assign w_tag_in.valid = w_accept;
    assign w_tag_in.id    = ID_MAX_W'(w_pick);

    cordic_tag_pipe #(
        .DEPTH (LATENCY + 1)
    ) u_tag_pipe (
        .clock  (clock),
        .reset  (reset),
        .i_tag  (w_tag_in),
        .o_tag  (w_tag_out),
        .o_busy (busy)
    );

    assign res_valid    = w_tag_out.valid;
    assign res_id       = w_tag_out.id[ID_W-1:0];
    assign res_sine     = res_valid ? cordic_sine : '0;
    assign w_tag_unused = &{1'b0, w_tag_out.id};

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter with a behavioural CORDIC stand-in (ideal
// K*amp*sin, LATENCY registers). Scoreboard of expected results plus a
// per-cycle round-robin grant model.
module tb_cordic_arbiter;
    import cordic_arb_pkg::*;

    localparam int N   = 4;
    localparam int W   = 10;
    localparam int LAT = 10;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [20*N-1:0]  req_angle;
    logic [W*N-1:0]   req_amp;
    logic [N-1:0]     req_ready;
    logic [19:0]      cordic_angle;
    logic [W-1:0]     cordic_x_start;
    logic [W-1:0]     cordic_y_start;
    logic [W-1:0]     cordic_sine;
    logic             res_valid;
    logic [1:0]       res_id;
    logic [W-1:0]     res_sine;
    logic             busy;

    always #5 clock = ~clock;

    cordic_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(LAT), .MAX_OUT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_angle      (req_angle),
        .req_amp        (req_amp),
        .req_ready      (req_ready),
        .cordic_angle   (cordic_angle),
        .cordic_x_start (cordic_x_start),
        .cordic_y_start (cordic_y_start),
        .cordic_sine    (cordic_sine),
        .res_valid      (res_valid),
        .res_id         (res_id),
        .res_sine       (res_sine),
        .busy           (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        n_tests++;
        if (((obs > exp) ? obs - exp : exp - obs) > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int model_sine(input logic [19:0] ang, input logic [W-1:0] amp);
        real a;
        a = $itor($signed(ang)) * 6.283185307179586 / 1048576.0;
        return int'($itor($signed(amp)) * 1.6467602581 * $sin(a));
    endfunction

    function automatic int next_rr(input int p, input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (((m >> ((p + k) % N)) & 4'd1) != 4'd0) return (p + k) % N;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (((v >> k) & 4'd1) != 4'd0) return k;
        return -1;
    endfunction

    // Behavioural CORDIC: input captured, result LAT cycles later, never reset
    logic [W-1:0] cpipe [LAT];
    always @(posedge clock) begin
        cpipe[0] <= W'(model_sine(cordic_angle, cordic_x_start));
        for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
    end
    assign cordic_sine = cpipe[LAT-1];

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int id; int sine; int cyc; } exp_t;
    exp_t         exp_q[$];
    int           gnt_id_q[$];
    int           gnt_cyc_q[$];
    int           mptr = 0;
    int           mcnt [N];
    int           res_cnt = 0;
    int           last_id = -1;
    int           last_sine = 0;
    logic [N-1:0] m_elig;
    int           m_exp_id;
    exp_t         m_e;

    // Monitor: grant model, scoreboard push on accept, pop on result
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            mptr = 0;
            foreach (mcnt[i]) mcnt[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
`ifdef CORDIC_ARB_CREDIT_EN
                m_elig[i] = req_valid[i] && (mcnt[i] < 4);
`else
                m_elig[i] = req_valid[i];
`endif
            end
            if (m_elig != '0) begin
                m_exp_id = next_rr(mptr, m_elig);
                chk("grant_onehot", $countones(req_ready), 1);
                chk("grant_id", onehot_idx(req_ready), m_exp_id);
                exp_q.push_back('{m_exp_id,
                    model_sine(req_angle[m_exp_id*20 +: 20], req_amp[m_exp_id*W +: W]), cyc});
                gnt_id_q.push_back(onehot_idx(req_ready));
                gnt_cyc_q.push_back(cyc);
                mptr = (m_exp_id + 1) % N;
                mcnt[m_exp_id]++;
            end else begin
                chk("idle_ready", int'(req_ready), 0);
            end
            if (res_valid) begin
                res_cnt++;
                last_id   = int'(res_id);
                last_sine = int'($signed(res_sine));
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("res_id", int'(res_id), m_e.id);
                    chk("res_sine", int'($signed(res_sine)), m_e.sine, 1);
                    chk("res_lat", cyc - m_e.cyc, 11);
                    mcnt[m_e.id]--;
                end
            end else if (cordic_sine != '0) begin
                chk("sine_gate", int'(res_sine), 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [19:0] ang, input logic [W-1:0] amp);
        req_angle[i*20 +: 20] = ang;
        req_amp[i*W +: W]     = amp;
        req_valid[i]          = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int snap;
        reset     = 1'b1;
        req_valid = '1;
        req_angle = '0;
        req_amp   = '0;

        // Reset state; offers during reset are never granted
        repeat (12) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_angle", int'(cordic_angle), 0);
        chk("rst_x", int'(cordic_x_start), 0);
        chk("rst_y", int'(cordic_y_start), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_sine", int'(res_sine), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clock); #1;
        reset     = 1'b0;
        req_valid = '0;
        tick(2);

        // Single job: requester 2, 90 degrees, amp 300
        snap = res_cnt;
        set_req(2, ANGLE_90, 10'd300);
        tick(1);
        req_valid = '0;
        tick(3);
        chk("busy_mid", int'(busy), 1);
        wait_drain(40);
        chk("t1_count", res_cnt - snap, 1);
        chk("t1_id", last_id, 2);
        chk("t1_sine", last_sine, 494, 1);

        // All four continuously valid, angle 0; pointer starts at 3
        g0 = gnt_id_q.size();
        for (int i = 0; i < N; i++) set_req(i, 20'h0, W'(100 + 20 * i));
        tick(8);
        req_valid = '0;
        wait_drain(40);
        chk("rot_n", gnt_id_q.size() - g0, 8);
        for (int k = 0; k < 8; k++) chk("rot_seq", gnt_id_q[g0 + k], (3 + k) % 4);
        chk("rot_sine", last_sine, 0, 2);

        // Requesters 1 and 3 only; pointer 3 -> 3,1,3,1,...
        g0 = gnt_id_q.size();
        set_req(1, 20'h20000, 10'd200);
        set_req(3, 20'h60000, 10'd150);
        tick(6);
        req_valid = '0;
        wait_drain(40);
        chk("alt_n", gnt_id_q.size() - g0, 6);
        for (int k = 0; k < 6; k++) chk("alt_seq", gnt_id_q[g0 + k], (k % 2 == 0) ? 3 : 1);

        // Reset mid-flight: three accepts dropped, no results for them
        set_req(0, ANGLE_90, 10'd250);
        tick(3);
        req_valid = '0;
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_busy", int'(busy), 0);
        chk("mid_res_valid", int'(res_valid), 0);
        chk("mid_res_sine", int'(res_sine), 0);
        chk("mid_angle", int'(cordic_angle), 0);
        chk("mid_x", int'(cordic_x_start), 0);
        snap = res_cnt;
        tick(20);
        chk("mid_flush", res_cnt - snap, 0);

        // -90 degrees on requester 1
        set_req(1, 20'hC0000, 10'd300);
        tick(1);
        req_valid = '0;
        wait_drain(40);
        chk("m90_id", last_id, 1);
        chk("m90_sine", last_sine, -494, 1);

        // Requester 0 held valid alone for 30 cycles
        g0 = gnt_id_q.size();
        set_req(0, 20'h10000, 10'd100);
        tick(30);
        req_valid = '0;
        wait_drain(60);
`ifdef CORDIC_ARB_CREDIT_EN
        chk("cr_n", gnt_id_q.size() - g0, 12);
        if (gnt_id_q.size() - g0 >= 5) begin
            chk("cr_burst", gnt_cyc_q[g0 + 3] - gnt_cyc_q[g0], 3);
            chk("cr_gap", gnt_cyc_q[g0 + 4] - gnt_cyc_q[g0], 12);
        end
`else
        chk("solo_n", gnt_id_q.size() - g0, 30);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
